// File: rtl/dmem_pkg.sv
// Shared types, widths and the address-legality helper for the data-memory responder.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    // A request is legal when it is word aligned and falls inside the array.
    function automatic logic addr_ok(input logic [31:0] addr, input int addr_w);
        logic [31:0] above;
        above = addr >> (addr_w + 2);
        return (addr[1:0] == 2'b00) && (above == 32'd0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [BE_W-1:0]   wr_be_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: storage arrays get no reset branch; resetting them would turn the RAM into flops.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (wr_be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (rd_en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory bus responder: captures a request, waits WAIT_CYCLES, then performs
// the access and pulses ready for one cycle with an error flag.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_ce_i,
    input  logic              data_we_i,
    input  logic [31:0]       data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    input  logic [BE_W-1:0]   data_be_i,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_ready_o,
    output logic              data_err_o,
    output logic              busy_o
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               req_we_q;
    logic [31:0]        req_addr_q;
    logic [DATA_W-1:0]  req_wdata_q;
    logic [BE_W-1:0]    req_be_q;
    logic               ready_q;
    logic               err_q;
    logic               rdata_valid_q;

    logic               acc_d;
    logic               acc_we_d;
    logic [31:0]        acc_addr_d;
    logic [DATA_W-1:0]  acc_wdata_d;
    logic [BE_W-1:0]    acc_be_d;
    logic               acc_err_d;
    logic [BE_W-1:0]    ram_wr_be;
    logic               ram_rd_en;
    logic [DATA_W-1:0]  ram_rdata;

    // The access fires on the edge that enters RESP; with no wait states that edge is
    // the capture edge itself, so the live bus fields are used instead of the registers.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        acc_d       = 1'b0;
        acc_we_d    = req_we_q;
        acc_addr_d  = req_addr_q;
        acc_wdata_d = req_wdata_q;
        acc_be_d    = req_be_q;
        if (state_q == IDLE) begin
            acc_d       = data_ce_i && (WAIT_CYCLES == 0);
            acc_we_d    = data_we_i;
            acc_addr_d  = data_addr_i;
            acc_wdata_d = data_wdata_i;
            acc_be_d    = data_be_i;
        end else if (state_q == WAIT) begin
            acc_d = (cnt_q == '0);
        end
        acc_err_d = !addr_ok(acc_addr_d, ADDR_W);
        ram_wr_be = (acc_d && acc_we_d && !acc_err_d) ? acc_be_d : '0;
        ram_rd_en = acc_d && !acc_we_d && !acc_err_d;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            req_we_q      <= 1'b0;
            req_addr_q    <= '0;
            req_wdata_q   <= '0;
            req_be_q      <= '0;
            ready_q       <= 1'b0;
            err_q         <= 1'b0;
            rdata_valid_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            if (acc_d) begin
                ready_q <= 1'b1;
                err_q   <= acc_err_d;
                if (!acc_we_d) begin
                    rdata_valid_q <= !acc_err_d;
                end
            end

            case (state_q)
                IDLE: begin
                    if (data_ce_i) begin
                        req_we_q    <= data_we_i;
                        req_addr_q  <= data_addr_i;
                        req_wdata_q <= data_wdata_i;
                        req_be_q    <= data_be_i;
                        if (WAIT_CYCLES > 0) begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .addr_i  (acc_addr_d[ADDR_W+1:2]),
        .wr_be_i (ram_wr_be),
        .wdata_i (acc_wdata_d),
        .rd_en_i (ram_rd_en),
        .rdata_o (ram_rdata)
    );

    // The RAM's read register holds the last good load; a faulted load or reset masks it to zero.
    assign data_rdata_o = rdata_valid_q ? ram_rdata : '0;
    assign data_ready_o = ready_q;
    assign data_err_o   = err_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-level memory model.
module tb_dmem_responder;

    localparam int ADDR_W = 10;
    localparam int WAITS  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_ce_i;
    logic        data_we_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_rdata_o;
    logic        data_ready_o;
    logic        data_err_o;
    logic        busy_o;

    int          n_tests = 0;
    int          n_fail  = 0;

    bit [31:0]   ref_mem [int];
    logic [31:0] last_rdata;

    dmem_responder #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAITS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_ce_i    (data_ce_i),
        .data_we_i    (data_we_i),
        .data_addr_i  (data_addr_i),
        .data_wdata_i (data_wdata_i),
        .data_be_i    (data_be_i),
        .data_rdata_o (data_rdata_o),
        .data_ready_o (data_ready_o),
        .data_err_o   (data_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the responder idle; returns at a negedge, idle again.
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be);
        int   cycles;
        bit   exp_err;
        int   idx;
        exp_err = (addr[1:0] != 2'b00) || (addr >= (32'd4 << ADDR_W));
        idx     = int'(addr >> 2);

        check("idle_busy", {31'd0, busy_o}, 32'd0);
        data_ce_i    = 1'b1;
        data_we_i    = we;
        data_addr_i  = addr;
        data_wdata_i = wdata;
        data_be_i    = be;

        @(posedge clk); #1;
        check("accept_busy", {31'd0, busy_o}, 32'd1);
        cycles = 0;
        while (!data_ready_o && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("latency", cycles, WAITS);

        if (we) begin
            if (!exp_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end else begin
            last_rdata = exp_err ? 32'd0 : ref_mem[idx];
        end
        check(we ? "store_err" : "load_err", {31'd0, data_err_o}, {31'd0, exp_err});
        check(we ? "store_rdata" : "load_rdata", data_rdata_o, last_rdata);

        @(negedge clk);
        data_ce_i = 1'b0;
        @(posedge clk); #1;
        check("ready_pulse", {30'd0, data_ready_o, data_err_o}, 32'd0);
        check("back_idle", {31'd0, busy_o}, 32'd0);
        check("rdata_hold", data_rdata_o, last_rdata);
        @(negedge clk);
    endtask

    initial begin
        last_rdata   = 32'd0;
        rst          = 1'b0;
        data_ce_i    = 1'b1;
        data_we_i    = 1'b1;
        data_addr_i  = 32'h10;
        data_wdata_i = 32'hDEADBEEF;
        data_be_i    = 4'hF;

        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {data_ready_o, data_err_o, busy_o}, 3'd0);
        check("rst_rdata", data_rdata_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        access(1'b0, 32'h10, 32'h0, 4'h0);
        check("plan_full_word", last_rdata, 32'hDEADBEEF);
        access(1'b1, 32'h10, 32'h11223344, 4'b0101);
        access(1'b0, 32'h10, 32'h0, 4'h0);
        check("plan_byte_en", data_rdata_o, 32'hDE22BE44);
        access(1'b1, 32'h13, 32'hCAFEF00D, 4'hF);
        access(1'b0, 32'h10, 32'h0, 4'h0);
        check("plan_misaligned", data_rdata_o, 32'hDE22BE44);
        access(1'b0, 32'h1000, 32'h0, 4'hF);
        access(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
        access(1'b0, 32'h10, 32'h0, 4'h0);

        // Reset during WAIT must drop the pending store.
        data_ce_i    = 1'b1;
        data_we_i    = 1'b1;
        data_addr_i  = 32'h10;
        data_wdata_i = 32'h0;
        data_be_i    = 4'hF;
        @(posedge clk); #1;
        check("midop_busy", {31'd0, busy_o}, 32'd1);
        @(negedge clk);
        rst       = 1'b0;
        data_ce_i = 1'b0;
        #1;
        check("midop_outputs", {data_ready_o, data_err_o, busy_o}, 3'd0);
        check("midop_rdata", data_rdata_o, 32'd0);
        last_rdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        access(1'b0, 32'h10, 32'h0, 4'h0);
        check("plan_store_dropped", data_rdata_o, 32'hDE22BE44);

        for (int w = 0; w < 16; w++) begin
            access(1'b1, 32'(w * 4), $urandom(), 4'hF);
        end

        for (int n = 0; n < 60; n++) begin
            int          kind;
            logic [31:0] addr;
            kind = $urandom_range(0, 9);
            addr = 32'($urandom_range(0, 15)) * 32'd4;
            if (kind == 0) addr = addr + 32'($urandom_range(1, 3));
            if (kind == 1) addr = ($urandom() | 32'h0000_1000) & 32'hFFFF_FFFC;
            access(1'($urandom_range(0, 1)), addr, $urandom(), 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data-memory bus: it accepts load/store requests driven by the core (chip enable, write enable, address, store data) and answers them. It holds a word-addressed data array, inserts a programmable number of wait states, and returns load data, a one-cycle ready pulse and an error flag. It sits between the core's data port and the data store, letting the core stall on memory latency.

## Interface
- ADDR_W, 10, word-address bits; array depth 2^ADDR_W words.
- WAIT_CYCLES, 1, wait states inserted per access; legal range 0..7.
- clk  in  1  system clock; the block uses this single clock.
- rst  in  1  reset, asynchronous and active-low.
- data_ce_i  in  1  request valid.
- data_we_i  in  1  1 = store, 0 = load.
- data_addr_i  in  32  byte address.
- data_wdata_i  in  32  store data.
- data_be_i  in  4  store byte enables; bit n covers bits 8n+7:8n.
- data_rdata_o  out  32  load data; valid while data_ready_o=1.
- data_ready_o  out  1  one-cycle completion pulse.
- data_err_o  out  1  request faulted; meaningful only with data_ready_o.
- busy_o  out  1  request in flight (state != IDLE).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if data_ce_i=1 at the rising edge, capture we, addr, wdata and be into request registers. Next state is WAIT with cnt = WAIT_CYCLES-1 if WAIT_CYCLES>0, otherwise RESP.
- WAIT: cnt decrements each edge. At cnt=0 the next state is RESP.
- Entering RESP, the access is performed from the captured request. For WAIT_CYCLES=0, the live inputs are used; these equal the captured values.
  - Load: data_rdata_o <= array[addr[ADDR_W+1:2]].
  - Store: write each byte whose enable bit is set. data_rdata_o is unchanged.
- RESP: data_ready_o=1 for exactly this cycle. The next state is always IDLE.
- The core holds data_ce_i and its request fields until it sees data_ready_o. The responder ignores input changes after capture.
- Error (data_err_o=1 with ready) when addr[1:0]!=0 or addr[31:ADDR_W+2]!=0.
  - An erroring store writes nothing.
  - An erroring load sets data_rdata_o=0.
- be=4'b0000 store: no-op, normal ready, no error.
- Loads ignore data_be_i and always return the full word.
- Array contents are not reset and are undefined until written.

## Timing
- Reset values: state=IDLE, cnt=0, data_rdata_o=0, data_ready_o=0, data_err_o=0, busy_o=0.
- Asserting reset at any time forces the reset values on the next cycle. A pending store is dropped and does not modify the array.
- Latency: request sampled at edge k, so data_ready_o is high in the cycle after edge k+WAIT_CYCLES.
- Throughput: one access per WAIT_CYCLES+2 cycles. data_ce_i sampled in RESP is ignored; the next request is sampled in IDLE.
- data_rdata_o holds its last load value until the next load or reset.
- data_err_o is 0 whenever data_ready_o is 0.
- busy_o is high in WAIT and RESP and low in IDLE.

## Structure
- Shared package dmem_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - DATA_W=32 and BE_W=4;
  - the helper that checks address alignment and range.
- Sub-module dmem_array: single-port synchronous word RAM with per-byte write enables and registered read data. It is instantiated once.
- FSM, wait counter, request capture and error logic live in dmem_responder.

## Test plan
- Reset: hold rst=0 with data_ce_i=1 -> all outputs 0, busy_o=0. Release -> first request accepted on the next edge.
- WAIT_CYCLES=2 store: 0xDEADBEEF to 0x10, be=1111, sampled at edge k.
  - data_ready_o high only in the cycle after edge k+2, with err=0.
  - A following load of 0x10 returns 0xDEADBEEF.
- Byte enables: store 0x11223344 to 0x10 with be=0101 over 0xDEADBEEF -> load returns 0xDE22BE44.
- Misaligned store: 0xCAFEF00D to 0x13 -> ready with err=1. A load of 0x10 still returns 0xDE22BE44.
- Out-of-range load: 0x1000 with ADDR_W=10 -> ready with err=1, data_rdata_o=0.
- Reset mid-operation: start a store of 0x0 to 0x10, then assert rst during WAIT.
  - Outputs clear.
  - After release, a load of 0x10 returns 0xDE22BE44.
